mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the single main-memory line port between the I-cache and D-cache miss engines.
//   Holds one outstanding line transaction at a time and picks the next owner round-robin.
//   Sits between both caches and the memory controller.
//   A cache whose request is waiting keeps its ready low, which the hazard unit turns into a pipeline stall.
// PARAMETERS
//   ADDR_W   32    line address width (byte address, line-aligned by requester)
//   LINE_W   128   cache line / memory beat width; one line per transaction
// PORTS
//   iClk        in   1       core clock; all state on rising edge
//   iRst_n      in   1       asynchronous active-low reset
//   iIcReq      in   1       I-cache line read request; held high until oIcAck
//   iIcAddr     in   ADDR_W  I-cache line address, stable while iIcReq high
//   oIcAck      out  1       one-cycle pulse: oIcData valid
//   oIcData     out  LINE_W  returned line for I-cache
//   iDcReq      in   1       D-cache request; held high until oDcAck
//   iDcWe       in   1       1 = line write-back, 0 = line fill
//   iDcAddr     in   ADDR_W  D-cache line address
//   iDcWdata    in   LINE_W  write-back data
//   oDcAck      out  1       one-cycle pulse: write done, or oDcData valid
//   oDcData     out  LINE_W  returned line for D-cache
//   oMemReq     out  1       memory request, held until iMemAck
//   oMemWe      out  1       memory write enable
//   oMemAddr    out  ADDR_W  memory line address
//   oMemWdata   out  LINE_W  memory write data
//   iMemAck     in   1       one-cycle completion from the memory controller
//   iMemRdata   in   LINE_W  read data, valid with iMemAck
// BEHAVIOUR
//   Reset (async, iRst_n=0)
//     - State goes to IDLE. All outputs are 0, including data buses.
//     - lastGrant is set to I-cache, so the D-cache wins the first tie.
//   FSM states
//     - IDLE: sample requests.
//       - One request high: grant it.
//       - Both high: grant the requester not equal to lastGrant.
//       - On grant: latch owner, addr, we (0 for I-cache), wdata; update lastGrant; go to ISSUE.
//       - No request: stay in IDLE.
//     - ISSUE: oMemReq=1. oMemWe/oMemAddr/oMemWdata come from the latched copies, stable for the whole state.
//       - On iMemAck: capture iMemRdata into the owner's data register; go to RESP.
//     - RESP: pulse the owner's ack for exactly 1 cycle; oMemReq=0; go to IDLE.
//   Latency
//     - Request high at edge t gives oMemReq at t+1.
//     - iMemAck in cycle m gives the owner ack in cycle m+1.
//     - Minimum turnaround is 3 cycles plus memory latency.
//   Data outputs
//     - oIcData/oDcData hold their value until the next transaction for the same cache.
//     - Data registers are not written on D-cache write-backs.
//   Requester drops its req the cycle after its ack
//     - IDLE follows RESP, so the dropped req is never re-granted.
//   Boundary conditions
//     - iMemAck outside ISSUE: ignored, no state change.
//     - iMemAck in the same cycle ISSUE is entered: illegal; the memory controller must wait ≥1 cycle.
//     - Request dropped before grant: nothing issued.
//     - Request dropped after grant: the transaction completes and the ack still pulses. Assertion flags this.
//     - Request address changing mid-transaction: no effect, because the latched copy is used.
//     - Both requests continuously high: strict alternation I/D/I/D; no starvation.
//     - Reset mid-ISSUE: transaction abandoned, no ack. The memory controller shares iRst_n.
//   SVA
//     - oIcAck and oDcAck are never both high.
//     - oMemReq is high only in ISSUE.
//     - Each ack pulse is exactly 1 cycle wide.
// STRUCTURE
//   - Shared processor package holds:
//     - state localparams ST_IDLE=2'd0, ST_ISSUE=2'd1, ST_RESP=2'd2;
//     - owner encoding OWN_IC=1'b0, OWN_DC=1'b1;
//     - default ADDR_W and LINE_W.
//   - Sub-module rr_arbiter2 (combinational grant plus registered lastGrant) makes the two-way round-robin pick.
//     The top level holds the FSM and the latches.
// TESTING
//   1. Reset: iRst_n=0 mid-ISSUE -> all outputs 0 in the same cycle; no ack after release; next req is served normally.
//   2. I-cache only: iIcAddr=0x0000_1000; mem acks 4 cycles after oMemReq with 0xA5..A5
//      -> oMemAddr=0x1000, oMemWe=0; oIcAck 1 cycle later; oIcData=0xA5..A5.
//   3. Tie after reset: both requests at the same edge -> D-cache served first, then I-cache; exactly 2 memory transactions.
//   4. D-cache write-back: iDcWe=1, addr 0x2040, wdata 0x1234 -> oMemWe=1, oMemWdata=0x1234; oDcAck pulses; oDcData unchanged.
//   5. Saturation: both requests held for 10 transactions -> grants alternate every transaction; neither requester is granted twice in a row.
//   6. Stray iMemAck in IDLE and in RESP -> no ack, no state change, data registers unchanged.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared encodings for the memory line-port arbiter:
//               FSM state codes, owner encoding and default widths.
// Revision    : 1.0  initial release
// ============================================================================
package mem_port_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_LINE_W = 128;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_RESP  = ST_RESP
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin pick between I-cache and D-cache.
//               Grant is combinational; the last winner is registered and
//               only advances when the grant is actually taken.
// Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter2
  import mem_port_arbiter_pkg::*;
(
  input  logic iClk,
  input  logic iRst_n,
  input  logic iReqIc,
  input  logic iReqDc,
  input  logic iTake,
  output logic oValid,
  output logic oOwner
);

  logic r_lastGrant;

  // Pick the lone requester, or on a tie the one that did not win last time
  always_comb begin
    oValid = iReqIc | iReqDc;
    oOwner = OWN_IC;
    if (iReqIc && iReqDc) begin
      oOwner = ~r_lastGrant;
    end else if (iReqDc) begin
      oOwner = OWN_DC;
    end
  end

  // Remember the winner; reset favours the D-cache on the first tie
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_lastGrant <= OWN_IC;
    end else if (iTake && oValid) begin
      r_lastGrant <= oOwner;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares the main-memory line port between the I-cache and
//               D-cache miss engines, one outstanding line at a time,
//               round-robin between the two requesters.
// Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iIcReq,
  input  logic [ADDR_W-1:0] iIcAddr,
  output logic              oIcAck,
  output logic [LINE_W-1:0] oIcData,
  input  logic              iDcReq,
  input  logic              iDcWe,
  input  logic [ADDR_W-1:0] iDcAddr,
  input  logic [LINE_W-1:0] iDcWdata,
  output logic              oDcAck,
  output logic [LINE_W-1:0] oDcData,
  output logic              oMemReq,
  output logic              oMemWe,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [LINE_W-1:0] oMemWdata,
  input  logic              iMemAck,
  input  logic [LINE_W-1:0] iMemRdata
);

  state_t            r_state;
  state_t            w_nextState;
  logic              r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic [LINE_W-1:0] r_icData;
  logic [LINE_W-1:0] r_dcData;
  logic              w_grantValid;
  logic              w_grantOwner;
  logic              w_take;

  assign w_take = (r_state == S_IDLE) && w_grantValid;

  rr_arbiter2 u_rr (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .iReqIc (iIcReq),
    .iReqDc (iDcReq),
    .iTake  (w_take),
    .oValid (w_grantValid),
    .oOwner (w_grantOwner)
  );

  // State register
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state plus the handshake outputs that depend only on state/owner
  always_comb begin
    w_nextState = r_state;
    oMemReq     = 1'b0;
    oIcAck      = 1'b0;
    oDcAck      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grantValid) w_nextState = S_ISSUE;
      end
      S_ISSUE: begin
        oMemReq = 1'b1;
        if (iMemAck) w_nextState = S_RESP;
      end
      S_RESP: begin
        oIcAck      = (r_owner == OWN_IC);
        oDcAck      = (r_owner == OWN_DC);
        w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Latch the winner's request so later changes on the cache side are ignored
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_owner <= OWN_IC;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_take) begin
      r_owner <= w_grantOwner;
      if (w_grantOwner == OWN_DC) begin
        r_we    <= iDcWe;
        r_addr  <= iDcAddr;
        r_wdata <= iDcWdata;
      end else begin
        r_we    <= 1'b0;
        r_addr  <= iIcAddr;
        r_wdata <= '0;
      end
    end
  end

  // Capture returned lines; write-backs leave the D-cache line untouched
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_icData <= '0;
      r_dcData <= '0;
    end else if ((r_state == S_ISSUE) && iMemAck) begin
      if (r_owner == OWN_IC) begin
        r_icData <= iMemRdata;
      end else if (!r_we) begin
        r_dcData <= iMemRdata;
      end
    end
  end

  assign oMemWe    = r_we;
  assign oMemAddr  = r_addr;
  assign oMemWdata = r_wdata;
  assign oIcData   = r_icData;
  assign oDcData   = r_dcData;

  aAckExclusive: assert property (@(posedge iClk) disable iff (!iRst_n)
    !(oIcAck && oDcAck));
  aMemReqOnlyIssue: assert property (@(posedge iClk) disable iff (!iRst_n)
    oMemReq |-> (r_state == S_ISSUE));
  aIcAckPulse: assert property (@(posedge iClk) disable iff (!iRst_n)
    oIcAck |=> !oIcAck);
  aDcAckPulse: assert property (@(posedge iClk) disable iff (!iRst_n)
    oDcAck |=> !oDcAck);
  aIcReqHeld: assert property (@(posedge iClk) disable iff (!iRst_n)
    ((r_state == S_ISSUE) && (r_owner == OWN_IC)) |-> iIcReq);
  aDcReqHeld: assert property (@(posedge iClk) disable iff (!iRst_n)
    ((r_state == S_ISSUE) && (r_owner == OWN_DC)) |-> iDcReq);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Scoreboard bench for mem_port_arbiter. Expected memory
//               transactions are queued when requests are raised and
//               consumed by a simple memory responder.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int LW = 128;

  logic          iClk = 1'b0;
  logic          iRst_n;
  logic          iIcReq;
  logic [AW-1:0] iIcAddr;
  logic          oIcAck;
  logic [LW-1:0] oIcData;
  logic          iDcReq;
  logic          iDcWe;
  logic [AW-1:0] iDcAddr;
  logic [LW-1:0] iDcWdata;
  logic          oDcAck;
  logic [LW-1:0] oDcData;
  logic          oMemReq;
  logic          oMemWe;
  logic [AW-1:0] oMemAddr;
  logic [LW-1:0] oMemWdata;
  logic          iMemAck;
  logic [LW-1:0] iMemRdata;

  typedef struct {
    logic          owner;
    logic          we;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
  } txn_t;

  txn_t          expQ[$];
  int            nChecks = 0;
  int            nErrors = 0;
  logic [LW-1:0] expIcData;
  logic [LW-1:0] expDcData;
  int            memReqCount = 0;
  logic          memReqPrev;

  always #5 iClk = ~iClk;

  mem_port_arbiter dut (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .iIcReq    (iIcReq),
    .iIcAddr   (iIcAddr),
    .oIcAck    (oIcAck),
    .oIcData   (oIcData),
    .iDcReq    (iDcReq),
    .iDcWe     (iDcWe),
    .iDcAddr   (iDcAddr),
    .iDcWdata  (iDcWdata),
    .oDcAck    (oDcAck),
    .oDcData   (oDcData),
    .oMemReq   (oMemReq),
    .oMemWe    (oMemWe),
    .oMemAddr  (oMemAddr),
    .oMemWdata (oMemWdata),
    .iMemAck   (iMemAck),
    .iMemRdata (iMemRdata)
  );

  // Count distinct memory transactions (rising edges of oMemReq)
  always @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      memReqPrev <= 1'b0;
    end else begin
      memReqPrev <= oMemReq;
      if (oMemReq && !memReqPrev) memReqCount <= memReqCount + 1;
    end
  end

  task automatic checkVal(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic pushTxn(input logic owner, input logic we, input logic [AW-1:0] addr,
                         input logic [LW-1:0] wdata, input logic [LW-1:0] rdata);
    txn_t t;
    t.owner = owner;
    t.we    = we;
    t.addr  = addr;
    t.wdata = wdata;
    t.rdata = rdata;
    expQ.push_back(t);
  endtask

  function automatic logic [LW-1:0] rndLine();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic checkReset(input string tag);
    checkVal({tag, "_memReq"},   LW'(oMemReq), '0);
    checkVal({tag, "_memWe"},    LW'(oMemWe), '0);
    checkVal({tag, "_memAddr"},  LW'(oMemAddr), '0);
    checkVal({tag, "_memWdata"}, oMemWdata, '0);
    checkVal({tag, "_acks"},     LW'({oIcAck, oDcAck}), '0);
    checkVal({tag, "_icData"},   oIcData, '0);
    checkVal({tag, "_dcData"},   oDcData, '0);
  endtask

  task automatic pulseReset();
    @(negedge iClk);
    iRst_n = 1'b0;
    @(negedge iClk);
    @(negedge iClk);
    iRst_n    = 1'b1;
    expIcData = '0;
    expDcData = '0;
  endtask

  // Memory responder: waits for the next issue, checks it against the
  // scoreboard, acks after lat cycles, then checks the cache-side response.
  task automatic serveNext(input int lat, input bit rereq, input bit dropAll, input bit stray);
    txn_t          t;
    bit            seen;
    logic [AW-1:0] savedAddr;
    if (expQ.size() == 0) begin
      checkVal("queueEmpty", LW'(1), LW'(0));
      return;
    end
    t    = expQ.pop_front();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge iClk);
      if (oMemReq) seen = 1'b1;
    end
    if (!seen) begin
      checkVal("memReqTimeout", LW'(0), LW'(1));
      return;
    end
    checkVal("memAddr", LW'(oMemAddr), LW'(t.addr));
    checkVal("memWe",   LW'(oMemWe),   LW'(t.we));
    if (t.we) checkVal("memWdata", oMemWdata, t.wdata);
    // Scramble the winner's address mid-transaction; the latched copy must hold
    if (t.owner == OWN_IC) begin
      savedAddr = iIcAddr;
      iIcAddr   = ~iIcAddr;
    end else begin
      savedAddr = iDcAddr;
      iDcAddr   = ~iDcAddr;
    end
    repeat (lat - 1) @(negedge iClk);
    checkVal("memAddrHeld", LW'(oMemAddr), LW'(t.addr));
    checkVal("noEarlyAck",  LW'({oIcAck, oDcAck}), '0);
    iMemAck   = 1'b1;
    iMemRdata = t.rdata;
    @(negedge iClk);
    iMemAck   = 1'b0;
    iMemRdata = '0;
    if (t.owner == OWN_IC) begin
      expIcData = t.rdata;
      iIcAddr   = savedAddr;
    end else begin
      if (!t.we) expDcData = t.rdata;
      iDcAddr = savedAddr;
    end
    checkVal("icAck",     LW'(oIcAck),  LW'(t.owner == OWN_IC));
    checkVal("dcAck",     LW'(oDcAck),  LW'(t.owner == OWN_DC));
    checkVal("memReqLow", LW'(oMemReq), '0);
    checkVal("icData",    oIcData, expIcData);
    checkVal("dcData",    oDcData, expDcData);
    if (dropAll) begin
      iIcReq = 1'b0;
      iDcReq = 1'b0;
    end else if (t.owner == OWN_IC) begin
      iIcReq = 1'b0;
    end else begin
      iDcReq = 1'b0;
    end
    if (stray) begin
      iMemAck   = 1'b1;
      iMemRdata = ~t.rdata;
    end
    @(negedge iClk);
    iMemAck   = 1'b0;
    iMemRdata = '0;
    checkVal("ackPulse",   LW'({oIcAck, oDcAck}), '0);
    checkVal("icDataHold", oIcData, expIcData);
    checkVal("dcDataHold", oDcData, expDcData);
    if (rereq) begin
      if (t.owner == OWN_IC) iIcReq = 1'b1;
      else iDcReq = 1'b1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  base;
    bit  seen;
    iRst_n    = 1'b0;
    iIcReq    = 1'b0;
    iIcAddr   = '0;
    iDcReq    = 1'b0;
    iDcWe     = 1'b0;
    iDcAddr   = '0;
    iDcWdata  = '0;
    iMemAck   = 1'b0;
    iMemRdata = '0;
    expIcData = '0;
    expDcData = '0;

    // Reset state
    repeat (3) @(negedge iClk);
    checkReset("reset");
    iRst_n = 1'b1;

    // I-cache only fill
    @(negedge iClk);
    iIcReq  = 1'b1;
    iIcAddr = 32'h0000_1000;
    pushTxn(OWN_IC, 1'b0, 32'h0000_1000, '0, {16{8'hA5}});
    serveNext(4, 1'b0, 1'b0, 1'b0);

    // D-cache write-back: data register untouched
    @(negedge iClk);
    iDcReq   = 1'b1;
    iDcWe    = 1'b1;
    iDcAddr  = 32'h0000_2040;
    iDcWdata = 128'h1234;
    pushTxn(OWN_DC, 1'b1, 32'h0000_2040, 128'h1234, rndLine());
    serveNext(4, 1'b0, 1'b0, 1'b0);
    iDcWe = 1'b0;

    // D-cache fill with a stray memory ack injected during RESP
    @(negedge iClk);
    iDcReq  = 1'b1;
    iDcAddr = 32'h0000_2080;
    pushTxn(OWN_DC, 1'b0, 32'h0000_2080, '0, rndLine());
    serveNext(3, 1'b0, 1'b0, 1'b1);

    // Stray memory ack while idle
    @(negedge iClk);
    iMemAck   = 1'b1;
    iMemRdata = '1;
    @(negedge iClk);
    iMemAck   = 1'b0;
    iMemRdata = '0;
    checkVal("strayIdleMemReq", LW'(oMemReq), '0);
    checkVal("strayIdleAcks",   LW'({oIcAck, oDcAck}), '0);
    checkVal("strayIdleIc",     oIcData, expIcData);
    checkVal("strayIdleDc",     oDcData, expDcData);
    @(negedge iClk);
    checkVal("strayIdleMemReq2", LW'(oMemReq), '0);

    // Reset in the middle of an issue: abandoned, then served afresh
    iIcReq  = 1'b1;
    iIcAddr = 32'h0000_3000;
    seen    = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge iClk);
      if (oMemReq) seen = 1'b1;
    end
    checkVal("midIssueReq", LW'(seen), LW'(1));
    #1;
    iRst_n = 1'b0;
    #1;
    checkReset("midIssueReset");
    expIcData = '0;
    expDcData = '0;
    @(negedge iClk);
    @(negedge iClk);
    iRst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge iClk);
      checkVal("noAckAfterReset", LW'({oIcAck, oDcAck}), '0);
    end
    pushTxn(OWN_IC, 1'b0, 32'h0000_3000, '0, rndLine());
    serveNext(2, 1'b0, 1'b0, 1'b0);

    // Tie right after reset: D-cache first, then I-cache, two transactions
    pulseReset();
    base = memReqCount;
    @(negedge iClk);
    iIcReq  = 1'b1;
    iIcAddr = 32'h0000_4000;
    iDcReq  = 1'b1;
    iDcWe   = 1'b0;
    iDcAddr = 32'h0000_5000;
    pushTxn(OWN_DC, 1'b0, 32'h0000_5000, '0, rndLine());
    pushTxn(OWN_IC, 1'b0, 32'h0000_4000, '0, rndLine());
    serveNext(2, 1'b0, 1'b0, 1'b0);
    serveNext(2, 1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge iClk);
    checkVal("tieTxnCount", LW'(memReqCount - base), LW'(2));

    // Saturation: both held, strict D/I alternation for 10 transactions
    base    = memReqCount;
    iIcReq  = 1'b1;
    iIcAddr = 32'h0000_6000;
    iDcReq  = 1'b1;
    iDcAddr = 32'h0000_7000;
    for (int k = 0; k < 10; k++) begin
      if (k % 2 == 0) pushTxn(OWN_DC, 1'b0, 32'h0000_7000, '0, rndLine());
      else            pushTxn(OWN_IC, 1'b0, 32'h0000_6000, '0, rndLine());
      serveNext(3, k < 9, k == 9, 1'b0);
    end
    repeat (5) @(negedge iClk);
    checkVal("satTxnCount", LW'(memReqCount - base), LW'(10));
    checkVal("satIdle",     LW'(oMemReq), '0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
`default_nettype wire
